// File: rtl/shift_add_multiplier.sv
// Sequential unsigned N x N -> 2N shift-and-add multiplier with start/busy/done handshake.
// Optional macro EARLY_TERM_EN ends the run once no multiplier bits remain.
module shift_add_multiplier #(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] product
);

  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state_reg;
  state_t         state_next;
  logic [2*N-1:0] mcand_reg;
  logic [2*N-1:0] acc_reg;
  logic [2*N-1:0] acc_sum;
  logic [2*N-1:0] product_reg;
  logic [N-1:0]   mplier_reg;
  logic [CW-1:0]  cnt_reg;
  logic           accept;
  logic           last;

  // DONE also accepts, so back-to-back requests skip the idle cycle.
  assign accept  = start && (state_reg != RUN);
  assign acc_sum = acc_reg + (mplier_reg[0] ? mcand_reg : '0);

`ifdef EARLY_TERM_EN
  assign last = (cnt_reg == CW'(N - 1)) || ((mplier_reg >> 1) == '0);
`else
  assign last = (cnt_reg == CW'(N - 1));
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    busy       = 1'b0;
    done       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) state_next = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last) state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = start ? RUN : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mcand_reg   <= '0;
      mplier_reg  <= '0;
      acc_reg     <= '0;
      cnt_reg     <= '0;
      product_reg <= '0;
    end else if (accept) begin
      mcand_reg  <= {{N{1'b0}}, a};
      mplier_reg <= b;
      acc_reg    <= '0;
      cnt_reg    <= '0;
    end else if (state_reg == RUN) begin
      acc_reg    <= acc_sum;
      mcand_reg  <= mcand_reg << 1;
      mplier_reg <= mplier_reg >> 1;
      cnt_reg    <= cnt_reg + CW'(1);
      // Result includes the add performed on the final edge.
      if (last) product_reg <= acc_sum;
    end
  end

  assign product = product_reg;

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Randomized self-checking bench for shift_add_multiplier against an arithmetic reference.
// Honours EARLY_TERM_EN when computing expected latency.
module tb_shift_add_multiplier;

  localparam int N     = 8;
  localparam int LIMIT = 200;

  logic           clk;
  logic           rst_n;
  logic           start;
  logic [N-1:0]   a;
  logic [N-1:0]   b;
  logic           busy;
  logic           done;
  logic [2*N-1:0] product;

  int n_checks = 0;
  int n_fail   = 0;

  shift_add_multiplier #(.N(N)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int exp_lat(input logic [N-1:0] y);
    int hi;
    hi = 0;
`ifdef EARLY_TERM_EN
    for (int i = 0; i < N; i++) if (y[i]) hi = i + 1;
    if (hi < 1) hi = 1;
`else
    hi = N;
`endif
    return hi;
  endfunction

  // Called at a negedge; returns at the negedge following the accepting edge.
  task automatic start_op(input logic [N-1:0] x, input logic [N-1:0] y);
    start = 1'b1;
    a     = x;
    b     = y;
    @(negedge clk);
    start = 1'b0;
    a     = N'($urandom);
    b     = N'($urandom);
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (busy && cyc < LIMIT) begin
      cyc++;
      @(negedge clk);
    end
    check("timeout", 64'(cyc >= LIMIT), 64'd0);
  endtask

  task automatic do_op(input logic [N-1:0] x, input logic [N-1:0] y, input bit chk_lat);
    int       cyc;
    logic [2*N-1:0] exp_p;
    exp_p = (2*N)'(x) * (2*N)'(y);
    start_op(x, y);
    wait_done(cyc);
    if (chk_lat) check("latency", 64'(cyc), 64'(exp_lat(y)));
    check("done_pulse", 64'(done), 64'd1);
    check("busy_with_done", 64'(busy), 64'd0);
    check("product", 64'(product), 64'(exp_p));
    $display("op a=%0d b=%0d product=%0d expected=%0d cycles=%0d", x, y, product, exp_p, cyc);
  endtask

  task automatic finish_check(input logic [2*N-1:0] held);
    @(negedge clk);
    check("done_drop", 64'(done), 64'd0);
    check("idle_busy", 64'(busy), 64'd0);
    check("product_hold", 64'(product), 64'(held));
  endtask

  initial begin
    int cyc;
    bit seen;
    logic [N-1:0] x;
    logic [N-1:0] y;

    rst_n = 1'b0;
    start = 1'b0;
    a     = '0;
    b     = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_product", 64'(product), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    do_op(8'd3, 8'd5, 1'b1);
    finish_check(16'd15);
    do_op(8'hFF, 8'hFF, 1'b1);
    finish_check(16'hFE01);
    do_op(8'hA5, 8'h00, 1'b1);
    finish_check(16'd0);

    // Reset at the fourth run edge aborts with no late completion.
    start_op(8'd9, 8'd9);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_product", 64'(product), 64'd0);
    rst_n = 1'b1;
    seen  = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (done || busy) seen = 1'b1;
    end
    check("late_done", 64'(seen), 64'd0);

    // A request during RUN is dropped.
    start_op(8'd7, 8'd3);
    start = 1'b1;
    a     = 8'd2;
    b     = 8'd2;
    @(negedge clk);
    start = 1'b0;
    wait_done(cyc);
    check("ignored_product", 64'(product), 64'd21);
    check("ignored_done", 64'(done), 64'd1);
    finish_check(16'd21);

    // Start held in the DONE cycle restarts immediately.
    do_op(8'd7, 8'd3, 1'b1);
    start_op(8'd4, 8'd6);
    check("b2b_done", 64'(done), 64'd0);
    check("b2b_busy", 64'(busy), 64'd1);
    check("b2b_product_hold", 64'(product), 64'd21);
    wait_done(cyc);
    check("b2b_latency", 64'(cyc), 64'(exp_lat(8'd6)));
    check("b2b_product", 64'(product), 64'd24);
    finish_check(16'd24);

    for (int i = 0; i < 40; i++) begin
      x = N'($urandom);
      y = (i % 3 == 0) ? N'($urandom_range(0, 15)) : N'($urandom);
      do_op(x, y, 1'b1);
      if (i % 2 == 0) finish_check((2*N)'(x) * (2*N)'(y));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
